regfile_wr_arbiter: RTL and testbench

Write-port arbiter for the register file's single write port (`wr`/`rw`/`d`). It shares that port between two writeback requesters over valid/ready handshakes. Requester A is the in-order pipeline writeback stage and has priority. Requester B is a long-latency source such as a mult/div or load-return unit, and is protected from starvation by a bounded-wait counter. Winning writes leave through a registered output stage that drives the register file directly.

---
 rtl/regfile_wr_arbiter_if.sv | 37 +++
 rtl/regfile_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port arbiter bus bundle.
//
// Groups the two writeback requester handshakes and the register-file write
// port that the arbiter drives.
//   a_valid/a_addr/a_data -> a_ready : in-order pipeline writeback (priority)
//   b_valid/b_addr/b_data -> b_ready : long-latency writeback (starvation-bounded)
//   wr/rw/d                          : registered register-file write port
//   starved                          : force-B condition active (debug/perf)
// modport master : requester/consumer side (testbench, pipeline)
// modport slave  : arbiter side
interface regfile_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;
  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] rw;
  logic [DATA_WIDTH-1:0] d;
  logic                  starved;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr, rw, d, starved
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr, rw, d, starved
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
//
// Shares the single register-file write port between requester A (pipeline
// writeback, priority) and requester B (long-latency unit). B is protected by
// a starvation counter: after STARVE_LIMIT consecutive lost cycles, B wins the
// next cycle. Winning writes are registered and appear on wr/rw/d one cycle
// after the grant. Writes to register 0 complete the handshake but never
// raise wr.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : regfile_wr_arbiter_if.slave (requester handshakes + write port)
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_DEPTH    = 32,
  parameter int ADDR_WIDTH   = $clog2(REG_DEPTH),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } arb_mode_t;

  arb_mode_t             mode_s;
  logic [3:0]            starve_cnt_r;
  logic [3:0]            starve_cnt_s;
  logic                  force_s;
  logic                  a_ready_s;
  logic                  b_ready_s;
  logic                  a_grant_s;
  logic                  b_grant_s;
  logic                  grant_s;
  logic [ADDR_WIDTH-1:0] grant_addr_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic                  wr_r;
  logic [ADDR_WIDTH-1:0] rw_r;
  logic [DATA_WIDTH-1:0] d_r;

  // Mode decode: the counter reaching the limit is the FORCE_B state.
  always_comb begin
    mode_s = NORMAL;
    if (starve_cnt_r == LIMIT) begin
      mode_s = FORCE_B;
    end else begin
      mode_s = NORMAL;
    end
  end

  // Grant logic; ready depends only on valids and mode, never on addr/data.
  always_comb begin
    force_s      = 1'b0;
    b_ready_s    = 1'b0;
    a_ready_s    = 1'b0;
    b_grant_s    = 1'b0;
    a_grant_s    = 1'b0;
    grant_s      = 1'b0;
    grant_addr_s = {ADDR_WIDTH{1'b0}};
    grant_data_s = {DATA_WIDTH{1'b0}};
    case (mode_s)
      NORMAL:  force_s = 1'b0;
      FORCE_B: force_s = 1'b1;
      default: force_s = 1'b0;
    endcase
    b_ready_s = !bus.a_valid || force_s;
    // A is ready when B is not taking the port this cycle.
    a_ready_s = !(bus.b_valid && b_ready_s);
    b_grant_s = bus.b_valid && b_ready_s;
    a_grant_s = bus.a_valid && a_ready_s;
    grant_s   = a_grant_s || b_grant_s;
    if (b_grant_s) begin
      grant_addr_s = bus.b_addr;
      grant_data_s = bus.b_data;
    end else begin
      grant_addr_s = bus.a_addr;
      grant_data_s = bus.a_data;
    end
  end

  // Starvation counter next state; increment only while below the limit, so it saturates.
  always_comb begin
    starve_cnt_s = starve_cnt_r;
    if (b_grant_s) begin
      starve_cnt_s = 4'd0;
    end else if (bus.b_valid && bus.a_valid && !force_s) begin
      starve_cnt_s = starve_cnt_r + 4'd1;
    end else if (!bus.b_valid) begin
      starve_cnt_s = 4'd0;
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else begin
      starve_cnt_r <= starve_cnt_s;
    end
  end

  // Registered write port; a grant in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_r <= 1'b0;
      rw_r <= {ADDR_WIDTH{1'b0}};
      d_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      // Register 0 is hard-wired zero: accept the write, never enable it.
      wr_r <= grant_s && (grant_addr_s != {ADDR_WIDTH{1'b0}});
      if (grant_s) begin
        rw_r <= grant_addr_s;
        d_r  <= grant_data_s;
      end else begin
        rw_r <= rw_r;
        d_r  <= d_r;
      end
    end
  end

  assign bus.a_ready = a_ready_s;
  assign bus.b_ready = b_ready_s;
  assign bus.starved = force_s;
  assign bus.wr      = wr_r;
  assign bus.rw      = rw_r;
  assign bus.d       = d_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model that
// tracks how many consecutive cycles B has lost and which write is due next.
module tb_regfile_wr_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int              losses = 0;   // consecutive cycles B waited and lost
  int              b_wait = 0;   // cycles the current B request has been presented
  logic            exp_wr = 1'b0;
  logic [AW-1:0]   exp_rw = '0;
  logic [DW-1:0]   exp_d  = '0;
  logic            last_ag = 1'b0;
  logic            last_bg = 1'b0;

  regfile_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_wr_arbiter #(
    .DATA_WIDTH  (DW),
    .REG_DEPTH   (32),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    bus.a_valid = v;
    bus.a_addr  = ad;
    bus.a_data  = dt;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    bus.b_valid = v;
    bus.b_addr  = ad;
    bus.b_data  = dt;
  endtask

  // One clock cycle: check readies and the write port against the model,
  // advance across the rising edge, then update the model.
  task automatic tick();
    logic fm, br, ar, ag, bg, av, bv, r;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd;
    #1;
    av = bus.a_valid; aa = bus.a_addr; ad = bus.a_data;
    bv = bus.b_valid; ba = bus.b_addr; bd = bus.b_data;
    r  = rst;
    fm = (losses == LIMIT);
    br = !av || fm;
    ar = !(bv && br);
    chk("a_ready", bus.a_ready, ar);
    chk("b_ready", bus.b_ready, br);
    chk("starved", bus.starved, fm);
    chk("wr", bus.wr, exp_wr);
    chk("rw", bus.rw, exp_rw);
    chk("d", bus.d, exp_d);
    bg = bv && br;
    ag = av && ar;
    if (bv) b_wait++;
    if (bg) chk("b_bound", (b_wait <= LIMIT + 1), 1'b1);
    last_ag = ag;
    last_bg = bg;
    @(posedge clk);
    if (r) begin
      losses = 0; b_wait = 0;
      exp_wr = 1'b0; exp_rw = '0; exp_d = '0;
    end else if (bg) begin
      losses = 0; b_wait = 0;
      exp_wr = (ba != 0); exp_rw = ba; exp_d = bd;
    end else if (ag) begin
      if (bv) losses = losses + 1;
      else begin losses = 0; b_wait = 0; end
      exp_wr = (aa != 0); exp_rw = aa; exp_d = ad;
    end else begin
      losses = 0; b_wait = 0;
      exp_wr = 1'b0;
    end
    #1;
  endtask

  initial begin
    int k;
    // Reset held two cycles with both requesters active.
    drive_a(1'b1, 5'd2, 32'h1234);
    drive_b(1'b1, 5'd9, 32'h5678);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    chk("reset_wr", bus.wr, 1'b0);
    chk("reset_rw", bus.rw, 5'd0);
    chk("reset_d", bus.d, 32'd0);
    chk("reset_starved", bus.starved, 1'b0);

    // Single requester A.
    drive_a(1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_a_ready", bus.a_ready, 1'b1);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);
    chk("single_wr", bus.wr, 1'b1);
    chk("single_rw", bus.rw, 5'd5);
    chk("single_d", bus.d, 32'hDEADBEEF);
    tick();
    chk("single_wr_low", bus.wr, 1'b0);

    // Starvation bound: A continuous, B waiting on addr 7.
    drive_a(1'b1, 5'd1, 32'h22);
    drive_b(1'b1, 5'd7, 32'h11);
    for (int c = 0; c < LIMIT; c++) begin
      #1 chk("starve_b_blocked", bus.b_ready, 1'b0);
      tick();
    end
    #1;
    chk("starve_flag", bus.starved, 1'b1);
    chk("starve_b_ready", bus.b_ready, 1'b1);
    chk("starve_a_ready", bus.a_ready, 1'b0);
    tick();
    chk("starve_wr", bus.wr, 1'b1);
    chk("starve_rw", bus.rw, 5'd7);
    chk("starve_d", bus.d, 32'h11);
    chk("starve_cleared", bus.starved, 1'b0);
    drive_b(1'b0, 5'd0, 32'd0);
    #1 chk("starve_a_again", bus.a_ready, 1'b1);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);
    tick();

    // Register zero write from B.
    drive_b(1'b1, 5'd0, 32'hFFFFFFFF);
    #1 chk("zero_b_ready", bus.b_ready, 1'b1);
    tick();
    drive_b(1'b0, 5'd0, 32'd0);
    chk("zero_wr", bus.wr, 1'b0);
    chk("zero_d", bus.d, 32'hFFFFFFFF);
    tick();

    // Same-address conflict: B forced on the second cycle at addr 3.
    drive_a(1'b1, 5'd1, 32'h33);
    drive_b(1'b1, 5'd3, 32'hB);
    repeat (LIMIT - 1) tick();
    drive_a(1'b1, 5'd3, 32'hA);
    tick();
    chk("same_a_wr", bus.wr, 1'b1);
    chk("same_a_rw", bus.rw, 5'd3);
    chk("same_a_d", bus.d, 32'hA);
    tick();
    chk("same_b_wr", bus.wr, 1'b1);
    chk("same_b_rw", bus.rw, 5'd3);
    chk("same_b_d", bus.d, 32'hB);
    drive_b(1'b0, 5'd0, 32'd0);
    tick();
    drive_a(1'b0, 5'd0, 32'd0);
    tick();

    // Reset mid-stream during alternating traffic.
    drive_b(1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 6; i++) begin
      drive_a((i % 2) == 0, 5'(i + 10), 32'(i));
      tick();
      if (last_bg) drive_b(1'b1, 5'(i + 20), 32'(i + 100));
    end
    drive_a(1'b1, 5'd12, 32'h77);
    drive_b(1'b1, 5'd13, 32'h88);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_wr", bus.wr, 1'b0);
    chk("midrst_rw", bus.rw, 5'd0);
    chk("midrst_d", bus.d, 32'd0);
    chk("midrst_starved", bus.starved, 1'b0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_bg && k < 20);
    chk("midrst_b_cycles", k, LIMIT + 1);
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      tick();
      if (!bus.a_valid || last_ag)
        drive_a($urandom_range(0, 3) != 0, AW'($urandom), $urandom);
      if (!bus.b_valid || last_bg)
        drive_b($urandom_range(0, 1) != 0, AW'($urandom), $urandom);
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
